// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Provides the request operation codes and the control FSM state encoding.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StFix
  } state_e;

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider core.
// Forms operand magnitudes on start, then produces one quotient bit per cycle for XLEN cycles.
// Outputs are unsigned magnitudes plus the sign-correction flags; the caller applies them.
//
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   start_i         load operands and begin (one cycle)
//   flush_i         abandon the current division
//   signed_i        treat operands as two's complement
//   dividend_i      dividend, sampled on start
//   divisor_i       divisor, sampled on start
//   finish_o        high during the last iteration cycle
//   quotient_o      quotient magnitude (valid the cycle after finish_o)
//   remainder_o     remainder magnitude (valid the cycle after finish_o)
//   neg_quot_o      quotient must be negated
//   neg_rem_o       remainder must be negated
//   div_zero_o      divisor was zero
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            finish_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            neg_quot_o,
  output logic            neg_rem_o,
  output logic            div_zero_o
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

  logic            active_q, active_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            neg_quot_q, neg_quot_d;
  logic            neg_rem_q, neg_rem_d;
  logic            zero_q, zero_d;

  logic            dvd_neg, dvs_neg;
  logic [XLEN-1:0] dvd_mag, dvs_mag;
  logic [XLEN:0]   rem_shift;
  logic [XLEN+1:0] diff;

  always_comb begin
    dvd_neg   = signed_i & dividend_i[XLEN-1];
    dvs_neg   = signed_i & divisor_i[XLEN-1];
    dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
    dvs_mag   = dvs_neg ? -divisor_i : divisor_i;
    // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
    rem_shift = {rem_q, quot_q[XLEN-1]};
    diff      = {1'b0, rem_shift} - {2'b00, dvsr_q};

    active_d   = active_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    zero_d     = zero_q;

    if (start_i) begin
      active_d   = 1'b1;
      cnt_d      = '0;
      rem_d      = '0;
      quot_d     = dvd_mag;
      dvsr_d     = dvs_mag;
      neg_quot_d = dvd_neg ^ dvs_neg;
      neg_rem_d  = dvd_neg;
      zero_d     = (divisor_i == '0);
    end else if (active_q) begin
      cnt_d = cnt_q + 1'b1;
      if (!diff[XLEN+1]) begin
        rem_d  = diff[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = rem_shift[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
      if (cnt_q == LastCnt) begin
        active_d = 1'b0;
      end
    end

    if (flush_i) begin
      active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_q   <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      zero_q     <= zero_d;
    end
  end

  assign finish_o    = active_q && (cnt_q == LastCnt);
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign neg_quot_o  = neg_quot_q;
  assign neg_rem_o   = neg_rem_q;
  assign div_zero_o  = zero_q;

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning the HI/LO register pair for the execute stage.
// Accepts one request at a time through a valid/ready handshake, runs a pipelined multiply or an
// iterative divide, and commits the result to HI/LO with a one-cycle done pulse. A flush cancels
// any in-flight operation without touching HI/LO.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   req_valid    request present
//   req_ready    unit idle and able to accept
//   req_op       MULT/MULTU/DIV/DIVU/MTHI/MTLO (6-7 accepted and ignored)
//   req_src1     dividend / multiplicand / move source
//   req_src2     divisor / multiplier
//   flush        cancel in-flight operation, drop any request this cycle
//   busy         multiply or divide in flight
//   done         HI/LO were just updated by a multiply or divide
//   hi, lo       committed HI/LO
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            done_q, done_d;

  logic accept, is_mul, is_div, mul_start, div_start;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready && !flush;
  assign is_mul    = (req_op == OP_MULT) || (req_op == OP_MULTU);
  assign is_div    = (req_op == OP_DIV) || (req_op == OP_DIVU);
  assign mul_start = accept && is_mul;
  assign div_start = accept && is_div;

  // Multiplier: full-width product from sign- or zero-extended operands.
  logic [2*XLEN-1:0] a_ext, b_ext, product;
  logic              mul_signed;

  always_comb begin
    mul_signed = (req_op == OP_MULT);
    a_ext      = {{XLEN{mul_signed & req_src1[XLEN-1]}}, req_src1};
    b_ext      = {{XLEN{mul_signed & req_src2[XLEN-1]}}, req_src2};
    product    = a_ext * b_ext;
  end

  logic [2*XLEN-1:0] mul_tail;
  logic              mul_tail_vld;

  // HI/LO themselves form the final pipe stage, so only MUL_LAT-1 registers sit in front of them.
  if (MUL_LAT == 1) begin : g_mul_comb
    assign mul_tail     = product;
    assign mul_tail_vld = mul_start;
  end else begin : g_mul_pipe
    localparam int unsigned Depth = MUL_LAT - 1;

    logic [2*XLEN-1:0] pipe_q [Depth];
    logic [2*XLEN-1:0] pipe_d [Depth];
    logic [Depth-1:0]  vld_q, vld_d;

    always_comb begin
      pipe_d   = pipe_q;
      vld_d    = vld_q;
      vld_d[0] = mul_start;
      if (mul_start) begin
        pipe_d[0] = product;
      end
      for (int i = 1; i < Depth; i++) begin
        vld_d[i]  = vld_q[i-1];
        pipe_d[i] = pipe_q[i-1];
      end
      if (flush) begin
        vld_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= '0;
      end else begin
        vld_q <= vld_d;
      end
    end

    always_ff @(posedge clk) begin
      pipe_q <= pipe_d;
    end

    assign mul_tail     = pipe_q[Depth-1];
    assign mul_tail_vld = vld_q[Depth-1];
  end

  // Divider.
  logic            div_finish, div_neg_quot, div_neg_rem, div_zero;
  logic [XLEN-1:0] div_quot, div_rem;

  div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_i     (div_start),
    .flush_i     (flush),
    .signed_i    (req_op == OP_DIV),
    .dividend_i  (req_src1),
    .divisor_i   (req_src2),
    .finish_o    (div_finish),
    .quotient_o  (div_quot),
    .remainder_o (div_rem),
    .neg_quot_o  (div_neg_quot),
    .neg_rem_o   (div_neg_rem),
    .div_zero_o  (div_zero)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (req_op)
            OP_MULT, OP_MULTU: state_d = (MUL_LAT > 1) ? StMul : StIdle;
            OP_DIV, OP_DIVU:   state_d = StDiv;
            OP_MTHI:           hi_d = req_src1;
            OP_MTLO:           lo_d = req_src1;
            default:           ;
          endcase
        end
      end
      StMul: begin
        if (mul_tail_vld) begin
          state_d = StIdle;
        end
      end
      StDiv: begin
        if (div_finish) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        // A zero divisor leaves |dividend| as the remainder, so undoing the dividend sign
        // recovers the original dividend for HI; only LO needs forcing.
        hi_d    = div_neg_rem ? -div_rem : div_rem;
        lo_d    = div_zero ? '1 : (div_neg_quot ? -div_quot : div_quot);
      end
      default: state_d = StIdle;
    endcase

    if (mul_tail_vld) begin
      {hi_d, lo_d} = mul_tail;
      done_d       = 1'b1;
    end

    // Flush beats any commit landing on the same edge.
    if (flush) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Parametrised multiply/divide unit that owns the HI/LO register pair for the EXE stage. It replaces the ad-hoc multiply/divide/HI-LO logic inside the execute stage with one block that has a valid/ready request handshake, an explicit busy/done status, and an iterative radix-2 divider. It also adds a flush input, so an exception can cancel an in-flight operation without corrupting HI/LO. The EXE stage stalls on req_ready/busy and reads hi/lo for MFHI/MFLO.

Parameters:
XLEN, 32, operand and HI/LO width; must be even and ≥ 8.
MUL_LAT, 2, multiply latency in cycles from accept to done; must be ≥ 1; implemented as a result pipeline.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  operation request.
req_ready  out  1  high when the unit can accept a request.
req_op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; values 6-7 are reserved and ignored.
req_src1  in  XLEN  rs value: dividend / multiplicand / MT source.
req_src2  in  XLEN  rt value: divisor / multiplier; ignored for MT*.
flush  in  1  cancel the in-flight operation (WB exception).
busy  out  1  a MUL or DIV operation is in flight.
done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
hi  out  XLEN  committed HI.
lo  out  XLEN  committed LO.

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0; the multiply pipe valid bits are cleared.
- Accept: a request is accepted when req_valid && req_ready && !flush. req_ready = (state==IDLE). Operands are captured at accept; later changes on the inputs have no effect.
- States:
  - IDLE.
  - MUL: lasts MUL_LAT cycles, counted from accept.
  - DIV: XLEN iterations.
  - FIX: one cycle of sign correction.
  - Transitions: IDLE→MUL on MULT/MULTU accept. IDLE→DIV on DIV/DIVU accept. MUL→IDLE when the counter expires. DIV→FIX after XLEN iterations. FIX→IDLE.
- MTHI/MTLO: accepted only in IDLE. hi (or lo) takes req_src1 at the accept edge. Do not change state or busy; no done pulse.
- MULT/MULTU:
  - Full 2*XLEN product, signed or unsigned per op.
  - At the completion edge: {hi,lo} <= product; done=1 in the next cycle; state returns to IDLE.
  - Latency: done is high in the cycle exactly MUL_LAT cycles after the accept cycle.
- DIV/DIVU:
  - Magnitudes are formed at accept; signed ops take absolute values.
  - Restoring shift-subtract, one quotient bit per cycle, XLEN cycles.
  - FIX negates the quotient if the operand signs differ (signed only). It negates the remainder if the dividend was negative (signed only).
  - At the FIX edge, lo <= quotient and hi <= remainder; done is high in the following cycle.
  - Latency: done is high XLEN+2 cycles after the accept cycle (32-bit: 34).
- Divide by zero: no trap. lo = all ones, hi = req_src1 unmodified. This applies to both signed and unsigned; the FIX step is bypassed for this case.
- Signed overflow, most-negative / -1: lo = most-negative, hi = 0. This falls out of the magnitude algorithm and must not be special-cased.
- busy = (state != IDLE). done is never asserted together with busy in the same cycle.
- Flush:
  - Flush in MUL, DIV or FIX: next state IDLE. hi/lo are unchanged and no done pulse follows.
  - Flush in the same cycle as a completion edge wins: that result is discarded.
  - Flush while IDLE, with req_valid high: the request is dropped, including MTHI/MTLO.
- Reset mid-operation: same as flush, and additionally hi=lo=0.
- A new request may be accepted in the same cycle done is high, because state is already IDLE.

Decomposition:
- Shared package (mdu_pkg):
  - Operation-code constants OP_MULT..OP_MTLO.
  - State encoding IDLE/MUL/DIV/FIX.
- Sub-module div_iter:
  - Owns the magnitude formation, the iteration counter, and the remainder/quotient shift registers.
  - Exposes start/flush/quotient/remainder/finish.
  - Lets the divider be verified in isolation.
- The multiplier stays inline as a behavioural product followed by a MUL_LAT-deep register pipe.

Test Plan:
1. Signed divide. Reset, then DIV src1=-7 (0xFFFFFFF9), src2=2 → busy for 33 cycles, done in cycle 34 after accept; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
2. Multiply, signed and unsigned. MULTU 0xFFFFFFFF×0xFFFFFFFF → after MUL_LAT=2 cycles, hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands → hi=0, lo=1.
3. Divide corner cases. DIVU 0x12345678/0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
4. Flush mid-divide. MTLO 0xAAAA5555, then DIV 100/7; assert flush on cycle 10 of DIV → state IDLE next cycle, no done, lo stays 0xAAAA5555, hi unchanged.
5. Handshake and back-to-back. Issue DIVU 100/7 while MULTU is busy → req_ready=0 and the request is held. It is accepted in the done cycle of MULTU; the final result is lo=14, hi=2.
6. Reset mid-multiply. Reset asserted one cycle after MULT accept → hi=lo=0, busy=0, done never pulses.
